// File: rtl/iod_read_train_ctrl_if.sv
// Handshake and pin bundle between the DDRPHY training FSM, one IOD lane and the
// read-training sequencer. master = sequencer side, slave = PHY/IOD side.
interface iod_read_train_ctrl_if #(
   parameter int unsigned TAP_W = 7
);
   logic             START;
   logic             BUSY;
   logic             DONE;
   logic             FAIL;
   logic [TAP_W-1:0] EYE_START;
   logic [TAP_W:0]   EYE_WIDTH;
   logic [TAP_W-1:0] CENTER_TAP;
   logic             DELAY_LINE_LOAD;
   logic             DELAY_LINE_MOVE;
   logic             DELAY_LINE_DIRECTION;
   logic             DELAY_LINE_OUT_OF_RANGE;
   logic             EYE_MONITOR_CLEAR_FLAGS;
   logic             EYE_MONITOR_EARLY;
   logic             EYE_MONITOR_LATE;

   modport master (
      input  START, DELAY_LINE_OUT_OF_RANGE, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
      output BUSY, DONE, FAIL, EYE_START, EYE_WIDTH, CENTER_TAP, DELAY_LINE_LOAD,
             DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS
   );

   modport slave (
      output START, DELAY_LINE_OUT_OF_RANGE, EYE_MONITOR_EARLY, EYE_MONITOR_LATE,
      input  BUSY, DONE, FAIL, EYE_START, EYE_WIDTH, CENTER_TAP, DELAY_LINE_LOAD,
             DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS
   );
endinterface

// File: rtl/iod_read_train_ctrl.sv
// Per-lane read-training sequencer: sweeps the IOD RX delay line, finds the longest
// passing tap window from the eye-monitor flags, then steps the line to its centre.
module iod_read_train_ctrl #(
   parameter int unsigned TAP_W      = 7,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned SAMPLE_CYC = 16,
   parameter int unsigned MIN_EYE    = 8
) (
   input  logic                  FAB_CLK,
   input  logic                  SYNC_RST,
   iod_read_train_ctrl_if.master bus
);

   localparam int unsigned CntMax = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYC - 1);
   localparam logic [CntW-1:0]  SampleLast = CntW'(SAMPLE_CYC - 1);
   localparam logic [CntW-1:0]  CntOne     = CntW'(1);
   localparam logic [TAP_W-1:0] TapOne     = TAP_W'(1);
   localparam logic [TAP_W-1:0] LastTap    = {TAP_W{1'b1}};
   localparam logic [TAP_W:0]   LenOne     = (TAP_W+1)'(1);
   localparam logic [TAP_W:0]   LenMax     = {1'b1, {TAP_W{1'b0}}};
   localparam logic [TAP_W:0]   MinEye     = (TAP_W+1)'(MIN_EYE);

   typedef enum logic [3:0] {
      StIdle, StLoad, StClear, StSettle, StSample, StEval, StStep,
      StCLoad, StCSettle, StCStep, StFinish
   } state_e;

   state_e           state_q, state_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             fail_q, fail_d;
   logic [TAP_W-1:0] run_start_q, run_start_d;
   logic [TAP_W:0]   run_len_q, run_len_d;
   logic [TAP_W-1:0] best_start_q, best_start_d;
   logic [TAP_W:0]   best_len_q, best_len_d;
   logic [TAP_W-1:0] center_q, center_d;
   logic [TAP_W-1:0] cur_q, cur_d;
   logic             pass_q, pass_d;
   logic [TAP_W-1:0] eye_start_q, eye_start_d;
   logic [TAP_W:0]   eye_width_q, eye_width_d;
   logic [TAP_W-1:0] center_tap_q, center_tap_d;

   logic             tap_pass, sweep_end, take;
   logic [TAP_W:0]   inc_len, cand_len, best_len_nx;
   logic [TAP_W-1:0] cand_start, best_start_nx, center_calc;

   // Candidate run is the run as it stands after this tap; it is only offered to
   // best when the run closes (failing tap or end of sweep).
   assign tap_pass      = !fail_q;
   assign sweep_end     = (tap_q == LastTap) || bus.DELAY_LINE_OUT_OF_RANGE;
   assign inc_len       = (run_len_q == LenMax) ? run_len_q : run_len_q + LenOne;
   assign cand_start    = (tap_pass && run_len_q == '0) ? tap_q : run_start_q;
   assign cand_len      = tap_pass ? inc_len : run_len_q;
   assign take          = (!tap_pass || sweep_end) && (cand_len > best_len_q);
   assign best_start_nx = take ? cand_start : best_start_q;
   assign best_len_nx   = take ? cand_len : best_len_q;
   assign center_calc   = best_start_q + TAP_W'((best_len_q - LenOne) >> 1);

   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      cnt_d        = cnt_q;
      fail_d       = fail_q;
      run_start_d  = run_start_q;
      run_len_d    = run_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      center_d     = center_q;
      cur_d        = cur_q;
      pass_d       = pass_q;
      eye_start_d  = eye_start_q;
      eye_width_d  = eye_width_q;
      center_tap_d = center_tap_q;
      unique case (state_q)
         StIdle: begin
            if (bus.START) begin
               state_d      = StLoad;
               tap_d        = '0;
               run_start_d  = '0;
               run_len_d    = '0;
               best_start_d = '0;
               best_len_d   = '0;
            end
         end
         StLoad: begin
            tap_d   = '0;
            state_d = StClear;
         end
         StClear: begin
            cnt_d   = '0;
            state_d = StSettle;
         end
         StSettle: begin
            if (cnt_q == SettleLast) begin
               cnt_d   = '0;
               fail_d  = 1'b0;
               state_d = StSample;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StSample: begin
            fail_d = fail_q | bus.EYE_MONITOR_EARLY | bus.EYE_MONITOR_LATE;
            if (cnt_q == SampleLast) state_d = StEval;
            else                     cnt_d   = cnt_q + CntOne;
         end
         StEval: begin
            run_start_d  = cand_start;
            run_len_d    = tap_pass ? inc_len : '0;
            best_start_d = best_start_nx;
            best_len_d   = best_len_nx;
            if (!sweep_end) begin
               state_d = StStep;
            end else if (best_len_nx >= MinEye) begin
               state_d = StCLoad;
            end else begin
               state_d      = StFinish;
               pass_d       = 1'b0;
               eye_start_d  = best_start_nx;
               eye_width_d  = best_len_nx;
               center_tap_d = '0;
            end
         end
         StStep: begin
            tap_d   = tap_q + TapOne;
            state_d = StClear;
         end
         StCLoad: begin
            center_d = center_calc;
            cur_d    = '0;
            cnt_d    = '0;
            state_d  = StCSettle;
         end
         StCSettle: begin
            if (cnt_q == SettleLast) begin
               cnt_d = '0;
               if (cur_q == center_q) begin
                  state_d      = StFinish;
                  pass_d       = 1'b1;
                  eye_start_d  = best_start_q;
                  eye_width_d  = best_len_q;
                  center_tap_d = center_q;
               end else begin
                  state_d = StCStep;
               end
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StCStep: begin
            cur_d   = cur_q + TapOne;
            state_d = StCSettle;
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         state_q      <= StIdle;
         tap_q        <= '0;
         cnt_q        <= '0;
         fail_q       <= 1'b0;
         run_start_q  <= '0;
         run_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
         center_q     <= '0;
         cur_q        <= '0;
         pass_q       <= 1'b0;
         eye_start_q  <= '0;
         eye_width_q  <= '0;
         center_tap_q <= '0;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         cnt_q        <= cnt_d;
         fail_q       <= fail_d;
         run_start_q  <= run_start_d;
         run_len_q    <= run_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
         center_q     <= center_d;
         cur_q        <= cur_d;
         pass_q       <= pass_d;
         eye_start_q  <= eye_start_d;
         eye_width_q  <= eye_width_d;
         center_tap_q <= center_tap_d;
      end
   end

   // Strobes decode straight from the state, so only one can be high per cycle.
   assign bus.BUSY                    = (state_q != StIdle);
   assign bus.DONE                    = (state_q == StFinish) && pass_q;
   assign bus.FAIL                    = (state_q == StFinish) && !pass_q;
   assign bus.DELAY_LINE_LOAD         = (state_q == StLoad) || (state_q == StCLoad);
   assign bus.DELAY_LINE_MOVE         = (state_q == StStep) || (state_q == StCStep);
   assign bus.DELAY_LINE_DIRECTION    = 1'b1;
   assign bus.EYE_MONITOR_CLEAR_FLAGS = (state_q == StClear);
   assign bus.EYE_START               = eye_start_q;
   assign bus.EYE_WIDTH               = eye_width_q;
   assign bus.CENTER_TAP              = center_tap_q;

endmodule

// File: tb/tb_iod_read_train_ctrl.sv
// Bench for iod_read_train_ctrl: a delay-line/eye-flag model driven by observed
// LOAD/MOVE pulses, directed eye shapes and randomized masks against a window model.
module tb_iod_read_train_ctrl;
   localparam int unsigned TAP_W = 7;

   logic FAB_CLK;
   logic SYNC_RST;

   iod_read_train_ctrl_if #(.TAP_W(TAP_W)) bus ();

   iod_read_train_ctrl #(
      .TAP_W(TAP_W), .SETTLE_CYC(4), .SAMPLE_CYC(16), .MIN_EYE(8)
   ) dut (
      .FAB_CLK(FAB_CLK),
      .SYNC_RST(SYNC_RST),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   bit [127:0] pass_mask;
   int         oor_tap = 1000;
   bit         clr_req = 1'b0;

   int n_load = 0, n_move = 0, n_clear = 0, n_done = 0, n_fail = 0, n_viol = 0;
   int line_tap = 0;
   bit prev_move = 1'b0;

   logic             c_timeout, c_busy_start, c_load_start, c_busy_after, c_relaunch;
   logic             c_done, c_fail;
   logic [TAP_W:0]   c_start, c_width, c_center;

   initial FAB_CLK = 1'b0;
   always #5 FAB_CLK = ~FAB_CLK;

   // Delay line + eye monitor model, sampled/driven on the falling edge.
   always @(negedge FAB_CLK) begin
      int r;
      if (clr_req) begin
         n_load = 0; n_move = 0; n_clear = 0; n_done = 0; n_fail = 0; n_viol = 0;
      end
      if ((int'(bus.DELAY_LINE_LOAD) + int'(bus.DELAY_LINE_MOVE)
           + int'(bus.EYE_MONITOR_CLEAR_FLAGS)) > 1) n_viol++;
      if (bus.DELAY_LINE_MOVE && prev_move) n_viol++;
      if (bus.DELAY_LINE_DIRECTION !== 1'b1) n_viol++;
      prev_move = bus.DELAY_LINE_MOVE;
      if (bus.DELAY_LINE_LOAD) begin line_tap = 0; n_load++; end
      if (bus.DELAY_LINE_MOVE) begin line_tap++; n_move++; end
      if (bus.EYE_MONITOR_CLEAR_FLAGS) n_clear++;
      if (bus.DONE) n_done++;
      if (bus.FAIL) n_fail++;
      r = $urandom_range(0, 1);
      if (line_tap < 0 || line_tap > 127 || !pass_mask[line_tap]) begin
         bus.EYE_MONITOR_EARLY = r[0];
         bus.EYE_MONITOR_LATE  = ~r[0];
      end else begin
         bus.EYE_MONITOR_EARLY = 1'b0;
         bus.EYE_MONITOR_LATE  = 1'b0;
      end
      bus.DELAY_LINE_OUT_OF_RANGE = (line_tap >= oor_tap);
   end

   task automatic tick();
      @(negedge FAB_CLK);
      #1;
   endtask

   task automatic set_window(input int lo, input int hi);
      for (int t = lo; t <= hi; t++) pass_mask[t] = 1'b1;
   endtask

   // Longest passing run over the swept taps; earlier window wins ties.
   task automatic ref_model(output int end_tap, output int bs, output int bl,
                            output int ctr, output bit ok);
      int run, rs;
      end_tap = (oor_tap < 127) ? oor_tap : 127;
      bs = 0; bl = 0; run = 0; rs = 0;
      for (int t = 0; t <= end_tap; t++) begin
         if (pass_mask[t]) begin
            if (run == 0) rs = t;
            run++;
            if (run > bl) begin bl = run; bs = rs; end
         end else begin
            run = 0;
         end
      end
      ok  = (bl >= 8);
      ctr = ok ? bs + (bl - 1) / 2 : 0;
   endtask

   task automatic run_training(input bit hold_start);
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      bus.START = 1'b1;
      tick();
      c_busy_start = bus.BUSY;
      c_load_start = bus.DELAY_LINE_LOAD;
      if (!hold_start) bus.START = 1'b0;
      c_timeout = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         if ((n_done + n_fail) != 0) begin c_timeout = 1'b0; break; end
         tick();
      end
      c_done = bus.DONE;
      c_fail = bus.FAIL;
      tick();
      c_busy_after = bus.BUSY;
      c_start  = (TAP_W+1)'(bus.EYE_START);
      c_width  = bus.EYE_WIDTH;
      c_center = (TAP_W+1)'(bus.CENTER_TAP);
      tick();
      c_relaunch = bus.DELAY_LINE_LOAD && bus.BUSY;
   endtask

   task automatic test_reset();
      SYNC_RST = 1'b1;
      bus.START = 1'b0;
      pass_mask = '0;
      tick(); tick();
      n_cmp++;
      if ({bus.BUSY, bus.DONE, bus.FAIL, bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE,
           bus.EYE_MONITOR_CLEAR_FLAGS, bus.DELAY_LINE_DIRECTION} !== 7'b0000001) begin
         n_err++;
         $display("FAIL reset_strobes got=%b exp=0000001", {bus.BUSY, bus.DONE, bus.FAIL,
                  bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE, bus.EYE_MONITOR_CLEAR_FLAGS,
                  bus.DELAY_LINE_DIRECTION});
      end
      n_cmp++;
      if ({bus.EYE_START, bus.EYE_WIDTH, bus.CENTER_TAP} !== '0) begin
         n_err++;
         $display("FAIL reset_results got=%0d/%0d/%0d exp=0/0/0", bus.EYE_START,
                  bus.EYE_WIDTH, bus.CENTER_TAP);
      end
      SYNC_RST = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      pass_mask = '0; set_window(20, 59); oor_tap = 1000;
      run_training(1'b0);
      n_cmp++; if (c_timeout !== 1'b0) begin n_err++; $display("FAIL basic_timeout got=%b exp=0", c_timeout); end
      n_cmp++; if (c_busy_start !== 1'b1 || c_load_start !== 1'b1) begin n_err++;
         $display("FAIL basic_accept busy=%b load=%b exp=1/1", c_busy_start, c_load_start); end
      n_cmp++; if (c_done !== 1'b1 || n_done != 1 || n_fail != 0) begin n_err++;
         $display("FAIL basic_done got=%b cnt=%0d/%0d exp=1 cnt=1/0", c_done, n_done, n_fail); end
      n_cmp++; if (n_move != 127 + 39 || n_load != 2 || n_clear != 128) begin n_err++;
         $display("FAIL basic_pulses move=%0d load=%0d clr=%0d exp=166/2/128", n_move, n_load, n_clear); end
      n_cmp++; if (c_start !== 20 || c_width !== 40 || c_center !== 39) begin n_err++;
         $display("FAIL basic_eye got=%0d/%0d/%0d exp=20/40/39", c_start, c_width, c_center); end
      n_cmp++; if (line_tap != 39) begin n_err++; $display("FAIL basic_line_tap got=%0d exp=39", line_tap); end
      n_cmp++; if (c_busy_after !== 1'b0 || c_relaunch !== 1'b0) begin n_err++;
         $display("FAIL basic_idle busy=%b relaunch=%b exp=0/0", c_busy_after, c_relaunch); end
      n_cmp++; if (n_viol != 0) begin n_err++; $display("FAIL basic_strobe_rules got=%0d exp=0", n_viol); end
   endtask

   task automatic test_ties();
      pass_mask = '0; set_window(10, 21); set_window(70, 81); oor_tap = 1000;
      run_training(1'b0);
      n_cmp++; if (c_done !== 1'b1 || c_timeout !== 1'b0) begin n_err++;
         $display("FAIL ties_done got=%b timeout=%b exp=1/0", c_done, c_timeout); end
      n_cmp++; if (c_start !== 10 || c_width !== 12 || c_center !== 15) begin n_err++;
         $display("FAIL ties_eye got=%0d/%0d/%0d exp=10/12/15", c_start, c_width, c_center); end
   endtask

   task automatic test_fail();
      pass_mask = '0; set_window(100, 104); oor_tap = 1000;
      run_training(1'b0);
      n_cmp++; if (c_fail !== 1'b1 || c_done !== 1'b0 || n_fail != 1 || n_done != 0) begin n_err++;
         $display("FAIL fail_pulse got=%b/%b cnt=%0d/%0d exp=1/0 cnt=1/0", c_fail, c_done, n_fail, n_done); end
      n_cmp++; if (n_load != 1 || n_move != 127) begin n_err++;
         $display("FAIL fail_no_centre load=%0d move=%0d exp=1/127", n_load, n_move); end
      n_cmp++; if (c_center !== 0 || c_start !== 100 || c_width !== 5) begin n_err++;
         $display("FAIL fail_eye got=%0d/%0d/%0d exp=100/5/0", c_start, c_width, c_center); end
      n_cmp++; if (c_busy_after !== 1'b0 || line_tap != 127) begin n_err++;
         $display("FAIL fail_exit busy=%b tap=%0d exp=0/127", c_busy_after, line_tap); end
   endtask

   task automatic test_oor();
      pass_mask = '0; set_window(30, 127); oor_tap = 50;
      run_training(1'b0);
      n_cmp++; if (c_done !== 1'b1 || n_clear != 51 || n_move != 50 + 40) begin n_err++;
         $display("FAIL oor_sweep done=%b clr=%0d move=%0d exp=1/51/90", c_done, n_clear, n_move); end
      n_cmp++; if (c_start !== 30 || c_width !== 21 || c_center !== 40) begin n_err++;
         $display("FAIL oor_eye got=%0d/%0d/%0d exp=30/21/40", c_start, c_width, c_center); end
      oor_tap = 1000;
   endtask

   task automatic test_last_tap();
      pass_mask = '0; set_window(120, 127); oor_tap = 1000;
      run_training(1'b0);
      n_cmp++; if (c_done !== 1'b1) begin n_err++; $display("FAIL last_done got=%b exp=1", c_done); end
      n_cmp++; if (c_start !== 120 || c_width !== 8 || c_center !== 123) begin n_err++;
         $display("FAIL last_eye got=%0d/%0d/%0d exp=120/8/123", c_start, c_width, c_center); end
   endtask

   task automatic test_mid_reset();
      bit seen;
      pass_mask = '1; oor_tap = 1000;
      clr_req = 1'b1; tick(); clr_req = 1'b0;
      bus.START = 1'b1; tick(); bus.START = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (line_tap == 33) begin seen = 1'b1; break; end
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         if (bus.EYE_MONITOR_CLEAR_FLAGS) break;
         tick();
      end
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL midrst_reach_tap33 got=%b exp=1", seen); end
      repeat (8) tick();
      SYNC_RST = 1'b1;
      tick();
      n_cmp++;
      if ({bus.BUSY, bus.DONE, bus.FAIL, bus.DELAY_LINE_LOAD, bus.DELAY_LINE_MOVE,
           bus.EYE_MONITOR_CLEAR_FLAGS, bus.DELAY_LINE_DIRECTION} !== 7'b0000001
          || {bus.EYE_START, bus.EYE_WIDTH, bus.CENTER_TAP} !== '0) begin
         n_err++;
         $display("FAIL midrst_outputs busy=%b done=%b fail=%b eye=%0d/%0d/%0d exp=0/0/0 0/0/0",
                  bus.BUSY, bus.DONE, bus.FAIL, bus.EYE_START, bus.EYE_WIDTH, bus.CENTER_TAP);
      end
      SYNC_RST = 1'b0;
      repeat (5) tick();
      n_cmp++; if (n_done + n_fail != 0 || bus.BUSY !== 1'b0) begin n_err++;
         $display("FAIL midrst_no_pulse cnt=%0d busy=%b exp=0/0", n_done + n_fail, bus.BUSY); end
      run_training(1'b0);
      n_cmp++; if (c_load_start !== 1'b1 || c_done !== 1'b1) begin n_err++;
         $display("FAIL midrst_restart load=%b done=%b exp=1/1", c_load_start, c_done); end
      n_cmp++; if (c_start !== 0 || c_width !== 128 || c_center !== 63 || line_tap != 63) begin n_err++;
         $display("FAIL midrst_full_eye got=%0d/%0d/%0d tap=%0d exp=0/128/63/63",
                  c_start, c_width, c_center, line_tap); end
   endtask

   task automatic test_back_to_back();
      bit fin;
      pass_mask = '0; set_window(0, 15); oor_tap = 15;
      run_training(1'b1);
      bus.START = 1'b0;
      n_cmp++; if (c_done !== 1'b1 || c_width !== 16 || c_center !== 7) begin n_err++;
         $display("FAIL b2b_first done=%b eye=%0d/%0d exp=1/16/7", c_done, c_width, c_center); end
      n_cmp++; if (c_busy_after !== 1'b0 || c_relaunch !== 1'b1 || n_load != 3) begin n_err++;
         $display("FAIL b2b_retrigger busy=%b relaunch=%b load=%0d exp=0/1/3",
                  c_busy_after, c_relaunch, n_load); end
      fin = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if (n_done == 2) begin fin = 1'b1; break; end
         tick();
      end
      tick();
      n_cmp++; if (fin !== 1'b1 || bus.EYE_WIDTH !== 16 || bus.BUSY !== 1'b0) begin n_err++;
         $display("FAIL b2b_second fin=%b width=%0d busy=%b exp=1/16/0", fin, bus.EYE_WIDTH, bus.BUSY); end
      oor_tap = 1000;
   endtask

   task automatic test_random(input int iters);
      int end_tap, bs, bl, ctr, s, l;
      bit ok;
      for (int it = 0; it < iters; it++) begin
         pass_mask = '0;
         for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
            s = $urandom_range(0, 120);
            l = $urandom_range(1, 30);
            for (int t = s; t < s + l && t < 128; t++) pass_mask[t] = 1'b1;
         end
         oor_tap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 127)) : 1000;
         ref_model(end_tap, bs, bl, ctr, ok);
         run_training(1'b0);
         n_cmp++; if (c_done !== ok || c_fail !== !ok || c_timeout !== 1'b0) begin n_err++;
            $display("FAIL rand%0d_outcome done=%b fail=%b exp=%b/%b", it, c_done, c_fail, ok, !ok); end
         n_cmp++; if (c_start !== bs || c_width !== bl || c_center !== ctr) begin n_err++;
            $display("FAIL rand%0d_eye got=%0d/%0d/%0d exp=%0d/%0d/%0d", it, c_start, c_width,
                     c_center, bs, bl, ctr); end
         n_cmp++; if (n_move != end_tap + ctr || line_tap != (ok ? ctr : end_tap) || n_viol != 0) begin
            n_err++;
            $display("FAIL rand%0d_line move=%0d tap=%0d viol=%0d exp=%0d/%0d/0", it, n_move,
                     line_tap, n_viol, end_tap + ctr, ok ? ctr : end_tap); end
      end
      oor_tap = 1000;
   endtask

   initial begin
      SYNC_RST  = 1'b1;
      bus.START = 1'b0;
      pass_mask = '0;
      test_reset();
      test_basic();
      test_ties();
      test_fail();
      test_oor();
      test_last_tap();
      test_mid_reset();
      test_back_to_back();
      test_random(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
